// File: rtl/vd_writeback_pkg.sv
// Shared widths, write-back FSM encodings and byte-mask helper for the vector write-back path.
package vd_writeback_pkg;

  localparam int unsigned VLEN       = 128;
  localparam int unsigned VLEN_BYTES = VLEN / 8;
  localparam int unsigned NUM_VREGS  = 32;
  localparam int unsigned ADDR_W     = $clog2(NUM_VREGS);
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned SEW_W      = 2;

  typedef logic [1:0] wb_state_t;

  localparam wb_state_t WB_IDLE   = 2'd0;
  localparam wb_state_t WB_ACTIVE = 2'd1;
  localparam wb_state_t WB_DRAIN  = 2'd2;
  localparam wb_state_t WB_FINISH = 2'd3;

  // Low count_bytes bits set; counts of VLEN_BYTES or more give an all-ones mask.
  function automatic logic [VLEN_BYTES-1:0] byte_mask(input logic [4:0] count_bytes);
    logic [VLEN_BYTES-1:0] m;
    m = '0;
    for (int i = 0; i < VLEN_BYTES; i++) begin
      m[i] = (5'(i) < count_bytes);
    end
    return m;
  endfunction

endpackage

// File: rtl/vd_writeback_tail_mask.sv
// Per-beat byte enables and element count for a register-group sequence with a partial tail.
module wb_tail_mask
  import vd_writeback_pkg::*;
(
  input  logic [CNT_W-1:0]      remaining,
  input  logic [SEW_W-1:0]      dest_sew,
  output logic [VLEN_BYTES-1:0] wr_be,
  output logic [CNT_W-1:0]      elems_this_beat
);

  logic [CNT_W-1:0] epr;
  logic [6:0]       tail_bytes;

  always_comb begin
    epr             = 5'(5'd16 >> dest_sew);
    tail_bytes      = 7'(remaining) << dest_sew;
    wr_be           = '1;
    elems_this_beat = epr;
    if (remaining <= epr) begin
      elems_this_beat = remaining;
      wr_be = (tail_bytes >= 7'd16) ? '1 : byte_mask(tail_bytes[4:0]);
    end
  end

endmodule

// File: rtl/vd_writeback.sv
// Vector write-back stage: turns vl/vsew/widening into VRF register writes with tail byte enables,
// holding one registered write toward the VRF port.
module vd_writeback
  import vd_writeback_pkg::*;
(
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     vd_addr,
  input  logic [CNT_W-1:0]      vl,
  input  logic [SEW_W-1:0]      vsew,
  input  logic                  widening,
  input  logic                  reduction,
  input  logic                  in_valid,
  input  logic [VLEN-1:0]       in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  wr_valid,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [VLEN-1:0]       wr_data,
  output logic [VLEN_BYTES-1:0] wr_be,
  input  logic                  wr_gnt,
  output logic                  busy,
  output logic                  done
);

  wb_state_t            state, state_nx;
  logic [CNT_W-1:0]     remaining, remaining_nx;
  logic [ADDR_W-1:0]    addr, addr_nx;
  logic [ADDR_W-1:0]    base, base_nx;
  logic [SEW_W-1:0]     dsew, dsew_nx;
  logic                 red, red_nx;
  logic                 wv_nx;
  logic [ADDR_W-1:0]    wa_nx;
  logic [VLEN-1:0]      wd_nx;
  logic [VLEN_BYTES-1:0] wbe_nx;

  logic [2:0]            sew_sum;
  logic [SEW_W-1:0]      dsew_in;
  logic [CNT_W-1:0]      tm_rem;
  logic [VLEN_BYTES-1:0] tm_be;
  logic [CNT_W-1:0]      tm_elems;
  logic [CNT_W-1:0]      rem_after;

  // Destination width saturates at 32b regardless of widening or vsew=3.
  assign sew_sum = 3'(vsew) + 3'(widening);
  assign dsew_in = (sew_sum > 3'd2) ? 2'd2 : sew_sum[1:0];

  // A reduction writes exactly one element, so the mask is computed for a count of 1.
  assign tm_rem    = red ? 5'd1 : remaining;
  assign rem_after = remaining - tm_elems;

  wb_tail_mask u_tail (
    .remaining      (tm_rem),
    .dest_sew       (dsew),
    .wr_be          (tm_be),
    .elems_this_beat(tm_elems)
  );

  assign busy = (state == WB_ACTIVE) || (state == WB_DRAIN);
  assign done = (state == WB_FINISH);

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    addr_nx      = addr;
    base_nx      = base;
    dsew_nx      = dsew;
    red_nx       = red;
    wv_nx        = wr_valid & ~wr_gnt;
    wa_nx        = wr_addr;
    wd_nx        = wr_data;
    wbe_nx       = wr_be;
    in_ready     = 1'b0;

    case (state)
      WB_IDLE: begin
        if (start) begin
          if (vl == '0) begin
            state_nx = WB_FINISH;
          end else begin
            remaining_nx = vl;
            addr_nx      = vd_addr;
            base_nx      = vd_addr;
            dsew_nx      = dsew_in;
            red_nx       = reduction;
            state_nx     = WB_ACTIVE;
          end
        end
      end

      WB_ACTIVE: begin
        // Single-entry buffer: a beat may load in the same cycle the held write is granted.
        in_ready = ~wr_valid | wr_gnt;
        if (in_valid && in_ready) begin
          if (!red) begin
            wv_nx        = 1'b1;
            wa_nx        = addr;
            wd_nx        = in_data;
            wbe_nx       = tm_be;
            addr_nx      = addr + 5'd1;
            remaining_nx = rem_after;
            if (rem_after == '0) state_nx = WB_DRAIN;
          end else if (in_last) begin
            wv_nx    = 1'b1;
            wa_nx    = base;
            wd_nx    = in_data;
            wbe_nx   = tm_be;
            state_nx = WB_DRAIN;
          end
        end
      end

      WB_DRAIN: begin
        if (!wr_valid || wr_gnt) state_nx = WB_FINISH;
      end

      WB_FINISH: state_nx = WB_IDLE;

      default: state_nx = WB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= WB_IDLE;
      remaining <= '0;
      addr      <= '0;
      base      <= '0;
      dsew      <= '0;
      red       <= 1'b0;
      wr_valid  <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      wr_be     <= '0;
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      addr      <= addr_nx;
      base      <= base_nx;
      dsew      <= dsew_nx;
      red       <= red_nx;
      wr_valid  <= wv_nx;
      wr_addr   <= wa_nx;
      wr_data   <= wd_nx;
      wr_be     <= wbe_nx;
    end
  end

endmodule

// File: tb/tb_vd_writeback.sv
// Self-checking bench for vd_writeback: vector table plus scoreboard, with hand-written
// backpressure, vl=0, start-while-busy and mid-operation reset sequences.
module tb_vd_writeback;

  logic         clk = 1'b0;
  logic         n_reset;
  logic         start;
  logic [4:0]   vd_addr;
  logic [4:0]   vl;
  logic [1:0]   vsew;
  logic         widening;
  logic         reduction;
  logic         in_valid;
  logic [127:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         wr_valid;
  logic [4:0]   wr_addr;
  logic [127:0] wr_data;
  logic [15:0]  wr_be;
  logic         wr_gnt;
  logic         busy;
  logic         done;

  vd_writeback dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (start),
    .vd_addr  (vd_addr),
    .vl       (vl),
    .vsew     (vsew),
    .widening (widening),
    .reduction(reduction),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_be    (wr_be),
    .wr_gnt   (wr_gnt),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  vsew;
    logic        widening;
    logic        reduction;
    logic [4:0]  vl;
    logic [4:0]  vd;
    int          rbeats;
    bit          rnd_gnt;
    int          exp_writes;
    logic [15:0] exp_last_be;
  } vec_t;

  typedef struct {
    logic [4:0]   a;
    logic [15:0]  be;
    logic [127:0] d;
  } wr_t;

  vec_t vecs[9];
  wr_t  exp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit gnt_manual = 1'b0;
  bit gnt_val    = 1'b0;
  bit gnt_rand   = 1'b0;
  bit mon_en     = 1'b1;

  int          nwr;
  int          last_gnt_cyc;
  logic [15:0] last_be;

  int m_rem, m_addr, m_epr, m_bpe, m_vd;
  bit m_red;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #2;
    wr_gnt = gnt_manual ? gnt_val : (gnt_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  // Scoreboard pop on every granted write, plus hold-stability under backpressure.
  logic         prev_v, prev_g;
  logic [149:0] prev_w;
  always @(negedge clk) begin
    if (!n_reset || !mon_en) begin
      prev_v = 1'b0;
      prev_g = 1'b0;
    end else begin
      if (prev_v && !prev_g)
        check("hold_stable", 160'({wr_valid, wr_addr, wr_be, wr_data}), 160'(prev_w));
      if (wr_valid && wr_gnt) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual addr=%0d be=%h required no write", wr_addr, wr_be);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 160'(wr_addr), 160'(e.a));
          check("wr_be", 160'(wr_be), 160'(e.be));
          check("wr_data", 160'(wr_data), 160'(e.d));
        end
        nwr++;
        last_be = wr_be;
        last_gnt_cyc = cyc;
      end
      prev_v = wr_valid;
      prev_g = wr_gnt;
      prev_w = {wr_valid, wr_addr, wr_be, wr_data};
    end
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_op(input logic [1:0] s, input logic w, input logic r,
                          input logic [4:0] l, input logic [4:0] d);
    int ds;
    ds = int'(s) + int'(w);
    if (ds > 2) ds = 2;
    m_epr = 16 >> ds;
    m_bpe = 1 << ds;
    m_rem = int'(l);
    m_addr = int'(d);
    m_vd = int'(d);
    m_red = r;
    nwr = 0;
    @(posedge clk); #1;
    start = 1'b1; vsew = s; widening = w; reduction = r; vl = l; vd_addr = d;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Reference model: expectation for one accepted beat.
  task automatic accept_beat(input logic [127:0] d, input logic last);
    wr_t e;
    int  n, bytes;
    if (m_red) begin
      if (last) begin
        e.a = 5'(m_vd);
        e.be = 16'((32'd1 << m_bpe) - 1);
        e.d = d;
        exp_q.push_back(e);
      end
    end else begin
      n = (m_rem < m_epr) ? m_rem : m_epr;
      bytes = n * m_bpe;
      e.a = 5'(m_addr);
      e.be = (bytes >= 16) ? 16'hFFFF : 16'((32'd1 << bytes) - 1);
      e.d = d;
      exp_q.push_back(e);
      m_addr = (m_addr + 1) % 32;
      m_rem = m_rem - n;
    end
  endtask

  task automatic wait_done(input int exp_writes, input logic [15:0] exp_last_be);
    int  k;
    bit  seen;
    seen = 1'b0;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    check("done_seen", 160'(seen), 160'(1));
    if (seen) begin
      check("done_latency", 160'(cyc), 160'(last_gnt_cyc + 1));
      check("done_busy", 160'(busy), 160'(0));
      check("write_count", 160'(nwr), 160'(exp_writes));
      check("last_be", 160'(last_be), 160'(exp_last_be));
      check("queue_empty", 160'(exp_q.size()), 160'(0));
      @(negedge clk);
      check("done_pulse", 160'(done), 160'(0));
    end
    exp_q.delete();
  endtask

  task automatic run_vec(input vec_t v);
    int nbeats, k, tmo;
    logic [127:0] d;
    gnt_rand = v.rnd_gnt;
    start_op(v.vsew, v.widening, v.reduction, v.vl, v.vd);
    nbeats = v.reduction ? v.rbeats : (int'(v.vl) + m_epr - 1) / m_epr;
    k = 0;
    tmo = 0;
    while (k < nbeats) begin
      d = rnd128();
      in_valid = 1'b1;
      in_data = d;
      in_last = v.reduction && (k == nbeats - 1);
      forever begin
        @(negedge clk);
        if (in_ready) break;
        tmo++;
        if (tmo > 200) break;
        @(posedge clk); #1;
      end
      if (tmo > 200) begin
        total++; bad++;
        $display("FAIL beat_timeout actual=no in_ready required=in_ready beat=%0d", k);
        break;
      end
      accept_beat(d, in_last);
      k++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    @(negedge clk);
    check("drain_ready", 160'(in_ready), 160'(0));
    wait_done(v.exp_writes, v.exp_last_be);
    gnt_rand = 1'b0;
  endtask

  initial begin
    logic [127:0] d0, d1;
    int t0;

    vecs[0] = '{2'd2, 1'b0, 1'b0, 5'd6,  5'd4,  0, 1'b0, 2, 16'h00FF};
    vecs[1] = '{2'd0, 1'b1, 1'b0, 5'd10, 5'd31, 0, 1'b0, 2, 16'h000F};
    vecs[2] = '{2'd2, 1'b0, 1'b1, 5'd4,  5'd7,  4, 1'b0, 1, 16'h000F};
    vecs[3] = '{2'd0, 1'b0, 1'b0, 5'd31, 5'd10, 0, 1'b1, 2, 16'h7FFF};
    vecs[4] = '{2'd2, 1'b0, 1'b0, 5'd31, 5'd28, 0, 1'b1, 8, 16'h0FFF};
    vecs[5] = '{2'd3, 1'b1, 1'b0, 5'd5,  5'd2,  0, 1'b0, 2, 16'h000F};
    vecs[6] = '{2'd1, 1'b0, 1'b0, 5'd8,  5'd0,  0, 1'b1, 1, 16'hFFFF};
    vecs[7] = '{2'd1, 1'b1, 1'b1, 5'd3,  5'd12, 2, 1'b1, 1, 16'h000F};
    vecs[8] = '{2'd0, 1'b0, 1'b1, 5'd1,  5'd30, 1, 1'b0, 1, 16'h0001};

    n_reset = 1'b0; start = 1'b0; vd_addr = '0; vl = '0; vsew = '0; widening = 1'b0;
    reduction = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; wr_gnt = 1'b0;
    nwr = 0; last_gnt_cyc = 0; last_be = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_outputs", 160'({in_ready, wr_valid, wr_addr, wr_be, wr_data, busy, done}), 160'(0));
    n_reset = 1'b1;
    @(negedge clk);
    check("idle_outputs", 160'({in_ready, wr_valid, busy, done}), 160'(0));

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    // Backpressure with a stray start while busy.
    gnt_manual = 1'b1; gnt_val = 1'b0;
    d0 = rnd128(); d1 = rnd128();
    start_op(2'd2, 1'b0, 1'b0, 5'd6, 5'd4);
    in_valid = 1'b1; in_data = d0;
    @(negedge clk);
    check("bp_ready0", 160'(in_ready), 160'(1));
    check("bp_busy", 160'(busy), 160'(1));
    accept_beat(d0, 1'b0);
    @(posedge clk); #1;
    in_data = d1;
    start = 1'b1; vd_addr = 5'd20; vl = 5'd1; vsew = 2'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready_low", 160'(in_ready), 160'(0));
      check("bp_hold", 160'({wr_valid, wr_addr, wr_be, wr_data}), 160'({1'b1, 5'd4, 16'hFFFF, d0}));
      @(posedge clk); #1;
      start = 1'b0;
    end
    gnt_val = 1'b1;
    @(negedge clk);
    check("bp_ready_grant", 160'(in_ready), 160'(1));
    accept_beat(d1, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_done(2, 16'h00FF);
    gnt_manual = 1'b0;

    // vl=0: done the cycle after start, no write.
    t0 = cyc;
    start_op(2'd2, 1'b0, 1'b0, 5'd0, 5'd9);
    @(negedge clk);
    check("vl0_done", 160'({done, wr_valid, busy}), 160'(3'b100));
    check("vl0_cycle", 160'(cyc), 160'(t0 + 2));
    @(negedge clk);
    check("vl0_pulse", 160'({done, wr_valid}), 160'(0));

    // Reset while a write is held.
    gnt_manual = 1'b1; gnt_val = 1'b0;
    start_op(2'd2, 1'b0, 1'b0, 5'd31, 5'd0);
    in_valid = 1'b1; in_data = rnd128();
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_busy", 160'({busy, wr_valid}), 160'(2'b11));
    #2;
    n_reset = 1'b0;
    #1;
    check("mid_rst_outputs", 160'({in_ready, wr_valid, wr_addr, wr_be, wr_data, busy, done}), 160'(0));
    in_valid = 1'b0;
    exp_q.delete();
    gnt_manual = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_idle", 160'({done, busy, wr_valid, in_ready}), 160'(0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vd_writeback.md
Name: vd_writeback

Overview:
- Write-back stage that accepts 128-bit result beats from the arithmetic stage and commits them to the vector register file (VRF).
- Converts vl, vsew and widening into a register-group address sequence and per-byte write enables, including a partial tail on the last beat.
- Reductions collapse to a single element-0 write.
- Holds one registered output entry with a valid/grant handshake toward the VRF write port.

Parameters:
- VLEN, 128, register width in bits; fixed, one beat equals one register.
- NREGS, 32, architectural vector registers; the address wraps modulo NREGS.

Ports:
- clk  in  1  clock
- n_reset  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse that latches the operation; ignored while busy=1
- vd_addr  in  5  base destination register
- vl  in  5  element count, 0..31
- vsew  in  2  source element width (0=8b, 1=16b, 2=32b, 3=treated as 32b)
- widening  in  1  destination element width is 2*SEW, saturated at 32b
- reduction  in  1  scalar result; only element 0 is written
- in_valid  in  1  result beat is present
- in_data  in  128  result beat, already packed at destination width
- in_last  in  1  final beat of a reduction; ignored for non-reductions
- in_ready  out  1  beat accepted when in_valid&in_ready
- wr_valid  out  1  VRF write request
- wr_addr  out  5  VRF register index
- wr_data  out  128  write data
- wr_be  out  16  byte enables
- wr_gnt  in  1  VRF accepts the write when wr_valid&wr_gnt
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse after the last write is granted

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0.
- Reset is honoured mid-operation: any pending write is dropped and no done pulse is produced.
- Widths on start:
  - dest_sew = min(vsew+widening, 2).
  - epr (elements per register) = 16 >> dest_sew.
  - bpe (bytes per element) = 1 << dest_sew.
- State IDLE:
  - busy=0, in_ready=0.
  - start with vl==0: go to FINISH; no write is issued.
  - start otherwise: latch the fields, set remaining=vl, set addr=vd_addr, go to ACTIVE.
- State ACTIVE:
  - in_ready = !wr_valid | wr_gnt (single-entry buffer; a new beat may be accepted in the same cycle the held write is granted).
  - Non-reduction accepted beat:
    - wr_data=in_data, wr_addr=addr.
    - If remaining>epr: wr_be=16'hFFFF.
    - Otherwise: wr_be has the low remaining*bpe bits set.
    - Then addr=addr+1 (mod 32) and remaining=remaining-min(remaining,epr).
    - When remaining reaches 0, go to DRAIN.
  - Reduction:
    - Beats with in_last=0 are consumed with no write.
    - The beat with in_last=1 issues one write: addr=vd_addr, wr_be has the low bpe bits set, wr_data=in_data. Then go to DRAIN.
- Output register:
  - wr_valid, wr_addr, wr_data and wr_be are registered, so the write appears the cycle after acceptance.
  - While wr_valid=1 and wr_gnt=0, all wr_* outputs stay stable.
  - wr_valid clears on a grant unless a new beat loads in the same cycle.
- State DRAIN: in_ready=0; when wr_valid==0, or wr_valid&wr_gnt, go to FINISH.
- State FINISH: done=1 for one cycle, busy=0, go to IDLE.
- busy is 1 in ACTIVE and DRAIN only.
- Latency: beat accept to wr_valid is 1 cycle. Last grant to done is 1 cycle.
- Maximum beats per operation is 8 (vl=31 at 32b).
- in_valid while in_ready=0 or in IDLE is ignored and not consumed.

Decomposition:
- accelerator_pkg additions:
  - wb_state_t enum {WB_IDLE, WB_ACTIVE, WB_DRAIN, WB_FINISH}.
  - Localparams VLEN_BYTES=16 and NUM_VREGS=32.
  - Function byte_mask(count_bytes) returning 16 bits.
- One natural sub-module: wb_tail_mask, combinational, taking (remaining, dest_sew) and producing (wr_be, elems_this_beat). It is reused by the load/store unit.

Test Plan:
- Basic 32b: vsew=2, vl=6, vd=4, wr_gnt tied 1, two beats → writes addr4 be=FFFF, then addr5 be=00FF; done 1 cycle after the second grant.
- Widening: vsew=0, widening=1, vl=10, vd=31 → dest 16b, epr=8 → writes addr31 be=FFFF, then addr0 be=000F (wrap).
- Reduction: vsew=2, reduction=1, vl=4, three beats in_last=0 then one in_last=1 with data 0x...0000_002A → exactly one write, addr=vd, be=000F, wr_data[31:0]=0x2A.
- Backpressure: wr_gnt=0 for 3 cycles with the first write held → wr_* stable, in_ready=0, the second beat is not consumed; after the grant, the sequence completes unchanged.
- Edge cases: vl=0 start → done at cycle+1, wr_valid never asserted. start while busy → ignored.
- Reset: assert n_reset low during ACTIVE → all outputs 0 immediately; after release, in IDLE and no done pulse.
